// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine: substitutes LANES bytes per clock
// through the inverse S-box, with valid/ready handshakes on both sides.
module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inState,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outState,
    output logic         busy
);

    localparam int STEPS = 16 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("LANES must be 1, 2, 4, 8 or 16");
    end

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    logic [1:0]          st;
    logic [CW-1:0]       cnt;
    logic [0:15][7:0]    work;
    logic [0:15][7:0]    work_nx;

    // Substitute the lanes selected by the byte counter.
    always_comb begin
        work_nx = work;
        for (int l = 0; l < LANES; l++) begin
            work_nx[4'(int'(cnt) * LANES + l)] =
                inv_sbox(work[4'(int'(cnt) * LANES + l)]);
        end
    end

    // Control FSM, byte counter and working register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= IDLE;
            cnt  <= '0;
            work <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (inValid) begin
                        work <= inState;
                        cnt  <= '0;
                        st   <= RUN;
                    end
                end
                RUN: begin
                    work <= work_nx;
                    if (cnt == LAST) begin
                        cnt <= '0;
                        st  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (outReady) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign inReady  = (st == IDLE);
    assign outValid = (st == DONE);
    assign busy     = (st != IDLE);
    assign outState = work;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Randomized self-checking bench for inv_sub_bytes_iter against an
// S-box model derived from GF(2^8) inversion and the affine map.
module tb_inv_sub_bytes_iter;

    localparam int LANES = 4;
    localparam int STEPS = 16 / LANES;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [127:0] inState;
    logic         outValid;
    logic         outReady;
    logic [127:0] outState;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbox_tab [256];
    logic [7:0] isbox_tab [256];

    inv_sub_bytes_iter #(.LANES(LANES)) dut (
        .clk(clk),
        .reset(reset),
        .inValid(inValid),
        .inReady(inReady),
        .inState(inState),
        .outValid(outValid),
        .outReady(outReady),
        .outState(outState),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from first principles, then invert the permutation.
    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
                          rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_tab[sbox_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127 - 8*i -: 8] = isbox_tab[s[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Hand over one state and wait for outValid; returns outState.
    task automatic do_op(input logic [127:0] s, output logic [127:0] r);
        int lat = 0;
        bit seen = 0;
        @(negedge clk);
        chk("in_ready_idle", inReady, 1);
        inValid = 1'b1;
        inState = s;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inState = rnd128();
        chk("busy_run", busy, 1);
        while (!seen && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            seen = outValid;
        end
        chk("latency", lat, STEPS);
        chk("in_ready_done", inReady, 0);
        r = outState;
    endtask

    // Full transaction with outReady high: one-cycle outValid pulse.
    task automatic run_check(input string tag, input logic [127:0] s,
                             input logic [127:0] exp);
        logic [127:0] r;
        outReady = 1'b1;
        do_op(s, r);
        chk(tag, r, exp);
        @(posedge clk);
        #1;
        chk("valid_drop", outValid, 0);
        chk("out_keep", outState, r);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [127:0] r;
        logic [127:0] s;
        reset    = 1'b1;
        inValid  = 1'b0;
        inState  = '0;
        outReady = 1'b1;
        build_model();
        chk("model_63", {120'h0, isbox_tab[8'h63]}, 128'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", outState, 0);
        chk("rst_valid", outValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", inReady, 1);
        @(negedge clk);
        reset = 1'b0;

        run_check("fips_vec", 128'h637c777bf26b6fc53001672bfed7ab76,
                  128'h000102030405060708090a0b0c0d0e0f);
        run_check("all_00", '0, {16{8'h52}});
        run_check("all_16", {16{8'h16}}, {16{8'hff}});

        // Every byte value once, round-tripped through the forward S-box.
        for (int k = 0; k < 16; k++) begin
            outReady = 1'b1;
            for (int j = 0; j < 16; j++) s[127 - 8*j -: 8] = 8'(16*k + j);
            do_op(s, r);
            for (int j = 0; j < 16; j++)
                chk("roundtrip", sbox_tab[r[127 - 8*j -: 8]],
                    s[127 - 8*j -: 8]);
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 20; k++) begin
            s = rnd128();
            run_check("random", s, model(s));
        end

        // Backpressure: hold DONE, poke inValid, result must not move.
        outReady = 1'b0;
        s = rnd128();
        do_op(s, r);
        chk("bp_first", r, model(s));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            inValid = 1'b1;
            inState = rnd128();
            @(posedge clk);
            #1;
            chk("bp_valid", outValid, 1);
            chk("bp_state", outState, r);
            chk("bp_ready", inReady, 0);
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", outValid, 0);
        chk("bp_idle", inReady, 1);
        chk("bp_keep", outState, r);

        // Abort on the second RUN cycle.
        @(negedge clk);
        inValid = 1'b1;
        inState = rnd128();
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_valid", outValid, 0);
        chk("abort_state", outState, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", inReady, 1);
        @(negedge clk);
        reset = 1'b0;
        s = rnd128();
        run_check("after_abort", s, model(s));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
